// File: rtl/ped_request.sv
// Pedestrian push-button front end: synchronise, debounce, latch one crossing request,
// hold it until acknowledged, then lock out new presses. Optional WAIT blink via PED_WAIT_BLINK_EN.
module ped_request #(
    parameter int DEBOUNCE_TICKS = 160000,
    parameter int LOCKOUT_TICKS  = 32000000,
    parameter int BLINK_TICKS    = 4000000
) (
    input  logic       pin3_clk_16mhz,
    input  logic       pin1_rst_n,
    input  logic       pin9_button_n,
    input  logic       ped_ack,
    output logic       ped_req,
    output logic       pin10_wait_led,
    output logic [7:0] served_count
);

    localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam int LK_W = (LOCKOUT_TICKS < 1) ? 1 : $clog2(LOCKOUT_TICKS + 1);
`ifdef PED_WAIT_BLINK_EN
    localparam int BL_W = $clog2(BLINK_TICKS + 1);
`endif

    if (DEBOUNCE_TICKS < 1 || BLINK_TICKS < 1 || LOCKOUT_TICKS < 0) begin : g_bad_param
        $error("ped_request: DEBOUNCE_TICKS and BLINK_TICKS must be >= 1, LOCKOUT_TICKS >= 0");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVING = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // All FSM-owned registers live in one struct so the state is visible in one place.
    typedef struct packed {
        state_t          state;
        logic            req;
        logic            led;
        logic [7:0]      served;
        logic [LK_W-1:0] lock_cnt;
`ifdef PED_WAIT_BLINK_EN
        logic [BL_W-1:0] blink_cnt;
`endif
    } fsm_t;

    logic            sync1;
    logic            sync2;
    logic            deb;
    logic            deb_d;
    logic [DB_W-1:0] deb_cnt;
    logic            press;
    fsm_t            r;
    fsm_t            nx;

    always_ff @(posedge pin3_clk_16mhz) begin
        if (!pin1_rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb     <= 1'b1;
            deb_d   <= 1'b1;
            deb_cnt <= '0;
        end else begin
            sync1 <= pin9_button_n;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 != deb) begin
                if (deb_cnt == DB_W'(DEBOUNCE_TICKS - 1)) begin
                    deb     <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Only a debounced press (1->0) counts; releases are silent.
    assign press = deb_d & ~deb;

    always_ff @(posedge pin3_clk_16mhz) begin
        if (!pin1_rst_n) begin
            r <= '0;
        end else begin
            r <= nx;
        end
    end

    // Handshake: ped_req stays high until ped_ack is seen high; ped_ack must then fall,
    // and only after the lockout expires can a fresh press raise ped_req again.
    always_comb begin
        nx = r;
        case (r.state)
            ST_IDLE: begin
                if (press && !ped_ack) begin
                    nx.state = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (ped_ack) begin
                    nx.state  = ST_SERVING;
                    nx.served = r.served + 8'd1;
                end
            end
            ST_SERVING: begin
                if (!ped_ack) begin
                    nx.state    = ST_LOCKOUT;
                    nx.lock_cnt = LK_W'(LOCKOUT_TICKS);
                end
            end
            ST_LOCKOUT: begin
                if (r.lock_cnt == '0) begin
                    nx.state = ST_IDLE;
                end else begin
                    nx.lock_cnt = r.lock_cnt - LK_W'(1);
                end
            end
            default: nx.state = ST_IDLE;
        endcase

        nx.req = (nx.state == ST_PENDING);

`ifdef PED_WAIT_BLINK_EN
        // LED lights on PENDING entry, then toggles every BLINK_TICKS cycles.
        if (nx.state != ST_PENDING) begin
            nx.led       = 1'b0;
            nx.blink_cnt = '0;
        end else if (r.state != ST_PENDING) begin
            nx.led       = 1'b1;
            nx.blink_cnt = '0;
        end else if (r.blink_cnt == BL_W'(BLINK_TICKS - 1)) begin
            nx.led       = ~r.led;
            nx.blink_cnt = '0;
        end else begin
            nx.blink_cnt = r.blink_cnt + BL_W'(1);
        end
`else
        nx.led = (nx.state == ST_PENDING);
`endif
    end

    assign ped_req        = r.req;
    assign pin10_wait_led = r.led;
    assign served_count   = r.served;

endmodule

// File: tb/tb_ped_request.sv
// Bench for ped_request: directed scenarios plus randomized presses/acks, each edge checked
// against a timeline-based reference model of request, LED, count and debounced button.
module tb_ped_request;

    localparam int D = 4;
    localparam int L = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b1;
    logic       ack = 1'b0;
    logic       ped_req;
    logic       led;
    logic [7:0] served_count;

    int n_cmp = 0;
    int n_err = 0;

    ped_request #(
        .DEBOUNCE_TICKS(D),
        .LOCKOUT_TICKS (L),
        .BLINK_TICKS   (B)
    ) dut (
        .pin3_clk_16mhz(clk),
        .pin1_rst_n    (rst_n),
        .pin9_button_n (btn),
        .ped_ack       (ack),
        .ped_req       (ped_req),
        .pin10_wait_led(led),
        .served_count  (served_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a delay line for the synchroniser, a sliding window for the
    // debouncer and a timeline (pending/serving/lockout-until-edge) for the request.
    logic       pipe[$];
    logic       win[$];
    logic       m_deb = 1'b1;
    logic       m_deb_last = 1'b1;
    bit         m_pending = 0;
    bit         m_serving = 0;
    bit         m_locked = 0;
    int         lock_end = 0;
    int         pend_start = 0;
    int         edge_no = 0;
    logic [7:0] m_count = 8'd0;

    task automatic model_edge(input logic r_n, input logic b, input logic a);
        logic s2;
        logic deb_new;
        bit   all_diff;
        bit   press;
        edge_no++;
        if (!r_n) begin
            pipe = '{1'b1, 1'b1};
            win.delete();
            m_deb = 1'b1;
            m_deb_last = 1'b1;
            m_pending = 0;
            m_serving = 0;
            m_locked = 0;
            m_count = 8'd0;
            return;
        end
        press = m_deb_last && !m_deb;
        s2 = pipe[1];
        win.push_back(s2);
        if (win.size() > D) void'(win.pop_front());
        deb_new = m_deb;
        all_diff = (win.size() == D);
        foreach (win[i]) if (win[i] == m_deb) all_diff = 0;
        if (all_diff) begin
            deb_new = s2;
            win.delete();
        end
        m_deb_last = m_deb;
        m_deb = deb_new;
        pipe.push_front(b);
        void'(pipe.pop_back());

        if (m_pending) begin
            if (a) begin
                m_pending = 0;
                m_serving = 1;
                m_count = m_count + 8'd1;
            end
        end else if (m_serving) begin
            if (!a) begin
                m_serving = 0;
                m_locked = 1;
                lock_end = edge_no + L + 1;
            end
        end else if (m_locked) begin
            if (edge_no >= lock_end) m_locked = 0;
        end else if (press && !a) begin
            m_pending = 1;
            pend_start = edge_no;
        end
    endtask

    function automatic logic model_led();
`ifdef PED_WAIT_BLINK_EN
        return m_pending && ((((edge_no - pend_start) / B) % 2) == 0);
`else
        return m_pending;
`endif
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge(rst_n, btn, ack);
            #1;
            check("req", {7'd0, ped_req}, {7'd0, m_pending});
            check("led", {7'd0, led}, {7'd0, model_led()});
            check("count", served_count, m_count);
            check("deb", {7'd0, dut.deb}, {7'd0, m_deb});
        end
    endtask

    logic exp_blink[6];

    initial begin
        pipe = '{1'b1, 1'b1};

        // Reset then clean press: button low from edge 10, request after edge 16.
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        check("reset_req", {7'd0, ped_req}, 8'd0);
        check("reset_led", {7'd0, led}, 8'd0);
        check("reset_count", served_count, 8'd0);
        tick(6);
        btn = 1'b0;
        tick(D + 2);
        check("press_early", {7'd0, ped_req}, 8'd0);
        tick(1);
        check("press_req", {7'd0, ped_req}, 8'd1);
        check("press_led", {7'd0, led}, 8'd1);
        check("press_count", served_count, 8'd0);

        // Handshake, with a press landing while the controller acknowledges.
        ack = 1'b1;
        tick(1);
        check("ack_req", {7'd0, ped_req}, 8'd0);
        check("ack_count", served_count, 8'd1);
        btn = 1'b1;
        tick(D + 2);
        btn = 1'b0;
        tick(D + 3);
        check("press_during_ack", {7'd0, ped_req}, 8'd0);
        btn = 1'b1;
        tick(D + 2);
        btn = 1'b0;
        tick(3);

        // Lockout: that press debounces 3 cycles after ack falls and is dropped.
        ack = 1'b0;
        tick(L + 1);
        check("lockout_req", {7'd0, ped_req}, 8'd0);
        tick(1);
        check("lockout_idle_req", {7'd0, ped_req}, 8'd0);
        btn = 1'b1;
        tick(D + 2);
        btn = 1'b0;
        tick(D + 2);
        check("relock_early", {7'd0, ped_req}, 8'd0);
        tick(1);
        check("after_lockout_req", {7'd0, ped_req}, 8'd1);

        // Reset in the middle of a pending request.
        rst_n = 1'b0;
        tick(1);
        check("midreset_req", {7'd0, ped_req}, 8'd0);
        check("midreset_led", {7'd0, led}, 8'd0);
        check("midreset_count", served_count, 8'd0);
        rst_n = 1'b1;
        btn = 1'b1;
        tick(D + 3);

        // Bounce: 3 low / 1 high, five times, never long enough to debounce.
        for (int j = 0; j < 5; j++) begin
            btn = 1'b0;
            tick(3);
            btn = 1'b1;
            tick(1);
            check("bounce_deb", {7'd0, dut.deb}, 8'd1);
            check("bounce_req", {7'd0, ped_req}, 8'd0);
        end
        tick(D + 3);

        // 256 full request cycles wrap the served counter back to 0.
        for (int j = 0; j < 256; j++) begin
            btn = 1'b0;
            tick(D + 3);
            ack = 1'b1;
            tick(2);
            ack = 1'b0;
            btn = 1'b1;
            tick(L + 4);
            if (j == 254) check("count_255", served_count, 8'd255);
        end
        check("count_wrap", served_count, 8'd0);

        // WAIT LED pattern across the first six PENDING cycles.
`ifdef PED_WAIT_BLINK_EN
        exp_blink = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_blink = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        btn = 1'b0;
        tick(D + 2);
        for (int j = 0; j < 6; j++) begin
            tick(1);
            check("blink_led", {7'd0, led}, {7'd0, exp_blink[j]});
        end
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        btn = 1'b1;
        tick(L + 4);

        // Randomized presses, bounces, acks, stray acks and resets.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            repeat ($urandom_range(0, 3)) begin
                btn = 1'b0;
                tick($urandom_range(1, D - 1));
                btn = 1'b1;
                tick(1);
            end
            btn = 1'b0;
            tick($urandom_range(D + 1, D + 6));
            tick($urandom_range(0, 4));
            ack = 1'b1;
            tick($urandom_range(1, 6));
            btn = 1'($urandom_range(0, 1));
            tick($urandom_range(0, 3));
            ack = 1'b0;
            tick($urandom_range(0, 4));
            btn = 1'b1;
            tick($urandom_range(2, L + 6));
            if ($urandom_range(0, 2) == 0) begin
                ack = 1'b1;
                tick(1);
                ack = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
